lmb_lsu: RTL
============

# lmb_lsu

Sequential, parametrised successor to the local memory bus adapter. It sits between the core's load/store stage and a word-wide synchronous memory port that has a request/grant handshake. It accepts one byte, half, word or (when XLEN=64) double access at a time, generates byte enables and lane-steered write data, and tolerates memory wait states. With the misalignment feature compiled in, it splits accesses that straddle a word boundary into two bus beats and reassembles the load result with zero or sign extension.

## Interface
Parameters:
- XLEN, 32: data width; 32 or 64 only. NB = XLEN/8 bytes per bus word; OB = log2(NB).
- ADDRLEN, 16: memory byte-address width; mem_addr is always NB-aligned.

Ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; all state is cleared on the clk edge while high.
- proc_req  in  1  access request; sampled only in IDLE.
- proc_we  in  1  1 = store, 0 = load.
- proc_addr  in  XLEN  byte address.
- proc_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64).
- proc_sign_ext_n  in  1  0 = sign-extend the load, 1 = zero-extend.
- proc_data_send  in  XLEN  store data, right-aligned.
- proc_busy  out  1  high in every non-IDLE state.
- proc_done  out  1  one-cycle completion pulse.
- proc_fault  out  1  valid with proc_done; flags an illegal size or a disallowed misaligned access.
- proc_data_receive  out  XLEN  load result; valid with proc_done, held until the next acceptance.
- mem_req  out  1  beat request; held until granted.
- mem_gnt  in  1  grant; mem_dataout is valid in the same cycle.
- mem_addr  out  ADDRLEN  word-aligned beat address.
- mem_wen  out  1  write beat.
- mem_ben  out  NB  byte enables.
- mem_datain  out  XLEN  lane-steered write data.
- mem_dataout  in  XLEN  read data.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- Acceptance: proc_req in IDLE latches addr, size, we, sign_ext_n and data. Define off = addr[OB-1:0] and len = 1<<size.
- Fault check: size 11 with XLEN=32, or a misaligned access with the feature compiled out, moves the FSM IDLE->RESP with fault=1 and generates no mem_req.
- Beat 0: mem_addr = addr with its low OB bits cleared. mem_ben = ((1<<len)-1)<<off, truncated to NB bits. mem_datain = data<<(8*off).
- Split condition: off+len > NB. If set, BEAT0 moves to BEAT1 on grant. Otherwise BEAT0 moves to RESP.
- Beat 1: mem_addr = beat-0 address + NB. mem_ben = (1<<(off+len-NB))-1. mem_datain = data>>(8*(NB-off)).
- BEAT1 moves to RESP on grant. RESP moves to IDLE unconditionally and pulses proc_done.
- Load assembly: capture beat0 data>>(8*off). If split, OR in beat1 data<<(8*(NB-off)). Then mask to len bytes and extend from bit 8*len-1 per proc_sign_ext_n. A double access on XLEN=64 is not extended.
- Stores leave proc_data_receive unchanged.
- proc_req while busy is ignored; the core must hold proc_req until proc_done.
- Address wrap at 2^ADDRLEN on beat 1 is modular and is not a fault.

## Timing
- Reset values: state IDLE; proc_busy, proc_done, proc_fault, mem_req and mem_wen are 0; mem_ben, mem_addr, mem_datain and proc_data_receive are 0.
- All outputs are registered.
- Aligned access with zero wait: request accepted at cycle 0, mem_req at cycle 1, grant at cycle 1, proc_done at cycle 2.
- Split access with zero wait: proc_done at cycle 3.
- Fault: proc_done at cycle 1.
- Each wait cycle (mem_req=1, mem_gnt=0) adds one cycle. The beat outputs stay stable while waiting.
- mem_gnt while mem_req=0 is ignored.
- Reset mid-beat: mem_req drops after the edge, the FSM returns to IDLE and any in-flight grant is discarded.

## Configuration
- ARCHER_LMB_MISALIGN_EN defined: two-beat splitting as described above.
- ARCHER_LMB_MISALIGN_EN undefined: BEAT1 and the merge logic are removed. Any access with off not a multiple of len faults without touching memory.

## Structure
- archerdefs.v holds the size encodings (LMB_SIZE_B/H/W/D) and the FSM state encodings.
- One combinational sub-module, lmb_lane_align: given off, len, sign_ext_n and the raw beat data, it produces the ben masks, the shifted store data and the extended load result. The FSM lives in lmb_lsu.

## Test plan
All scenarios use XLEN=32 with memory preloaded as 0x100=0x44332211 and 0x104=0x88776655.
- Aligned LW at 0x104, no wait -> one beat with ben 1111; proc_data_receive=0x88776655 at cycle 2.
- LB at 0x107 with sign_ext_n=0 -> 0xFFFFFF88. Same access with sign_ext_n=1 -> 0x00000088.
- Misaligned LW at 0x102 with the macro on -> beats (0x100, ben 1100) then (0x104, ben 0011); result 0x66554433 at cycle 3.
- Misaligned SW of 0xDEADBEEF at 0x103, with 2 wait cycles per beat -> beat 0 (0x100, ben 1000, datain 0xEF000000), beat 1 (0x104, ben 0111, datain 0x00DEADBE); proc_done at cycle 7.
- Macro off, LH at 0x103 -> no mem_req; proc_done and proc_fault both high at cycle 1. Size 11 -> fault at cycle 1.
- Reset asserted during a BEAT0 wait -> mem_req=0 and proc_busy=0 after the edge; a later grant is ignored.

Source files
------------

// File: rtl/lmb_lsu_pkg.sv
// lmb_lsu_pkg: shared encodings for the local-memory-bus load/store unit.
// Holds the access-size codes, the sequencer state encoding and a size helper.
package lmb_lsu_pkg;

  localparam logic [1:0] LMB_SIZE_B = 2'b00;
  localparam logic [1:0] LMB_SIZE_H = 2'b01;
  localparam logic [1:0] LMB_SIZE_W = 2'b10;
  localparam logic [1:0] LMB_SIZE_D = 2'b11;

  typedef enum logic [1:0] {
    LMB_IDLE  = 2'b00,
    LMB_BEAT0 = 2'b01,
    LMB_BEAT1 = 2'b10,
    LMB_RESP  = 2'b11
  } lmb_state_e;

  // Number of bytes moved by an access of the given size code.
  function automatic logic [3:0] lmb_size_len(input logic [1:0] size);
    lmb_size_len = 4'd1 << size;
  endfunction

endpackage

// File: rtl/lmb_lane_align.sv
// lmb_lane_align: combinational byte-lane steering for lmb_lsu.
// Produces both beats' byte enables and store data, the split and misalignment
// flags, and the reassembled, masked and extended load result.
module lmb_lane_align
  import lmb_lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OB   = $clog2(NB)
) (
  input  logic [OB-1:0]   off,
  input  logic [1:0]      size,
  input  logic            sign_ext_n,
  input  logic            merge,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata0,
  input  logic [XLEN-1:0] rdata1,
  output logic            split,
  output logic            misaligned,
  output logic [NB-1:0]   ben0,
  output logic [NB-1:0]   ben1,
  output logic [XLEN-1:0] wdata0,
  output logic [XLEN-1:0] wdata1,
  output logic [XLEN-1:0] load_data
);

  // Wide enough for an 8-byte mask shifted by the largest offset.
  localparam int MW = 3 * NB;
  localparam logic [MW-1:0] ONE_M = {{(MW-1){1'b0}}, 1'b1};

  logic [3:0]        len_s;
  logic [4:0]        end_s;
  logic [MW-1:0]     mask_s;
  logic [2*XLEN-1:0] wide_store_s;
  logic [2*XLEN-1:0] wide_load_s;
  logic [2*XLEN-1:0] shifted_load_s;
  logic [XLEN-1:0]   raw_s;
  logic              sign_s;

  // Byte-enable masks for both beats plus split/misalignment detection
  always_comb begin
    len_s      = lmb_size_len(size);
    end_s      = 5'(off) + 5'(len_s);
    split      = (end_s > 5'(NB));
    misaligned = ((4'(off) & (len_s - 4'd1)) != 4'd0);
    mask_s     = ((ONE_M << len_s) - ONE_M) << off;
    ben0       = mask_s[NB-1:0];
    ben1       = mask_s[2*NB-1:NB];
  end

  // Store data steered into lanes; the part crossing the word lands in beat 1
  always_comb begin
    wide_store_s = {{XLEN{1'b0}}, store_data} << {off, 3'b000};
    wdata0       = wide_store_s[XLEN-1:0];
    wdata1       = wide_store_s[2*XLEN-1:XLEN];
  end

  // Load reassembly, masking to the access length and zero/sign extension
  always_comb begin
    if (merge) begin
      wide_load_s = {rdata1, rdata0};
    end else begin
      wide_load_s = {{XLEN{1'b0}}, rdata0};
    end
    shifted_load_s = wide_load_s >> {off, 3'b000};
    raw_s          = shifted_load_s[XLEN-1:0];
    case (size)
      LMB_SIZE_B: sign_s = raw_s[7];
      LMB_SIZE_H: sign_s = raw_s[15];
      LMB_SIZE_W: sign_s = raw_s[31];
      default:    sign_s = 1'b0;
    endcase
    load_data = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (i < 8 * int'(len_s)) begin
        load_data[i] = raw_s[i];
      end else begin
        load_data[i] = sign_s & ~sign_ext_n;
      end
    end
  end

endmodule

// File: rtl/lmb_lsu.sv
// lmb_lsu: sequential load/store adapter between the core and a word-wide
// request/grant memory port. Define ARCHER_LMB_MISALIGN_EN to split accesses
// that cross a word boundary into two beats; without it they fault.
module lmb_lsu
  import lmb_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDRLEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               proc_req,
  input  logic               proc_we,
  input  logic [XLEN-1:0]    proc_addr,
  input  logic [1:0]         proc_size,
  input  logic               proc_sign_ext_n,
  input  logic [XLEN-1:0]    proc_data_send,
  output logic               proc_busy,
  output logic               proc_done,
  output logic               proc_fault,
  output logic [XLEN-1:0]    proc_data_receive,
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic [ADDRLEN-1:0] mem_addr,
  output logic               mem_wen,
  output logic [XLEN/8-1:0]  mem_ben,
  output logic [XLEN-1:0]    mem_datain,
  input  logic [XLEN-1:0]    mem_dataout
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam logic [ADDRLEN-1:0] NB_STEP = ADDRLEN'(NB);

  lmb_state_e         state_q, state_d;
  logic [OB-1:0]      off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               we_q, we_d;
  logic               sxn_q, sxn_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic               req_q, req_d;
  logic               wen_q, wen_d;
  logic [NB-1:0]      ben_q, ben_d;
  logic [ADDRLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0]    wdat_q, wdat_d;
`ifdef ARCHER_LMB_MISALIGN_EN
  logic [XLEN-1:0]    beat0_q, beat0_d;
`endif

  logic [OB-1:0]   al_off_s;
  logic [1:0]      al_size_s;
  logic [XLEN-1:0] al_data_s;
  logic            al_merge_s;
  logic [XLEN-1:0] al_rdata0_s;
  logic            split_s;
  logic            misaligned_s;
  logic [NB-1:0]   ben0_s, ben1_s;
  logic [XLEN-1:0] wdata0_s, wdata1_s, load_s;
  logic            acc_fault_s;

  // Feed the lane aligner with the incoming request in IDLE, the latched one afterwards
  always_comb begin
    if (state_q == LMB_IDLE) begin
      al_off_s  = proc_addr[OB-1:0];
      al_size_s = proc_size;
      al_data_s = proc_data_send;
    end else begin
      al_off_s  = off_q;
      al_size_s = size_q;
      al_data_s = data_q;
    end
`ifdef ARCHER_LMB_MISALIGN_EN
    al_merge_s  = (state_q == LMB_BEAT1);
    al_rdata0_s = al_merge_s ? beat0_q : mem_dataout;
`else
    al_merge_s  = 1'b0;
    al_rdata0_s = mem_dataout;
`endif
  end

  lmb_lane_align #(.XLEN(XLEN)) u_align (
    .off        (al_off_s),
    .size       (al_size_s),
    .sign_ext_n (sxn_q),
    .merge      (al_merge_s),
    .store_data (al_data_s),
    .rdata0     (al_rdata0_s),
    .rdata1     (mem_dataout),
    .split      (split_s),
    .misaligned (misaligned_s),
    .ben0       (ben0_s),
    .ben1       (ben1_s),
    .wdata0     (wdata0_s),
    .wdata1     (wdata1_s),
    .load_data  (load_s)
  );

  // Decide at acceptance whether the access may reach memory at all
  always_comb begin
`ifdef ARCHER_LMB_MISALIGN_EN
    acc_fault_s = (proc_size == LMB_SIZE_D) && (XLEN < 64);
`else
    acc_fault_s = ((proc_size == LMB_SIZE_D) && (XLEN < 64)) || misaligned_s;
`endif
  end

  // Next state and next registered outputs of the access sequencer
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    we_d    = we_q;
    sxn_d   = sxn_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    req_d   = req_q;
    wen_d   = wen_q;
    ben_d   = ben_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
`ifdef ARCHER_LMB_MISALIGN_EN
    beat0_d = beat0_q;
`endif
    case (state_q)
      LMB_IDLE: begin
        if (proc_req) begin
          off_d  = proc_addr[OB-1:0];
          size_d = proc_size;
          we_d   = proc_we;
          sxn_d  = proc_sign_ext_n;
          data_d = proc_data_send;
          busy_d = 1'b1;
          if (acc_fault_s) begin
            state_d = LMB_RESP;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d = LMB_BEAT0;
            req_d   = 1'b1;
            wen_d   = proc_we;
            addr_d  = {proc_addr[ADDRLEN-1:OB], {OB{1'b0}}};
            ben_d   = ben0_s;
            wdat_d  = wdata0_s;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      LMB_BEAT0: begin
        if (mem_gnt) begin
`ifdef ARCHER_LMB_MISALIGN_EN
          if (split_s) begin
            state_d = LMB_BEAT1;
            beat0_d = mem_dataout;
            addr_d  = addr_q + NB_STEP;
            ben_d   = ben1_s;
            wdat_d  = wdata1_s;
          end else begin
            state_d = LMB_RESP;
            done_d  = 1'b1;
            req_d   = 1'b0;
            wen_d   = 1'b0;
            rdata_d = we_q ? rdata_q : load_s;
          end
`else
          state_d = LMB_RESP;
          done_d  = 1'b1;
          req_d   = 1'b0;
          wen_d   = 1'b0;
          rdata_d = we_q ? rdata_q : load_s;
`endif
        end else begin
          state_d = LMB_BEAT0;
        end
      end
`ifdef ARCHER_LMB_MISALIGN_EN
      LMB_BEAT1: begin
        if (mem_gnt) begin
          state_d = LMB_RESP;
          done_d  = 1'b1;
          req_d   = 1'b0;
          wen_d   = 1'b0;
          rdata_d = we_q ? rdata_q : load_s;
        end else begin
          state_d = LMB_BEAT1;
        end
      end
`endif
      LMB_RESP: begin
        state_d = LMB_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = LMB_IDLE;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        wen_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LMB_IDLE;
      off_q   <= '0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      sxn_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      ben_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
`ifdef ARCHER_LMB_MISALIGN_EN
      beat0_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sxn_q   <= sxn_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      wen_q   <= wen_d;
      ben_q   <= ben_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
`ifdef ARCHER_LMB_MISALIGN_EN
      beat0_q <= beat0_d;
`endif
    end
  end

  assign proc_busy         = busy_q;
  assign proc_done         = done_q;
  assign proc_fault        = fault_q;
  assign proc_data_receive = rdata_q;
  assign mem_req           = req_q;
  assign mem_wen           = wen_q;
  assign mem_ben           = ben_q;
  assign mem_addr          = addr_q;
  assign mem_datain        = wdat_q;

  // Aligner outputs that only one build flavour consumes.
`ifdef ARCHER_LMB_MISALIGN_EN
  logic unused_align_s;
  assign unused_align_s = misaligned_s;
`else
  logic unused_align_s;
  assign unused_align_s = ^{split_s, ben1_s, wdata1_s};
`endif

  // Address bits above the memory's reach are not decoded.
  if (ADDRLEN < XLEN) begin : g_addr_unused
    logic unused_addr_s;
    assign unused_addr_s = ^proc_addr[XLEN-1:ADDRLEN];
  end

endmodule
